// File: rtl/pcie_us_axis_cq_demux.sv
// Purpose : Routes whole UltraScale CQ request TLPs from one 128-bit AXI stream to one of
//           M_COUNT output streams, selected by the descriptor BAR ID. TLPs for unmapped BARs
//           are dropped and counted.
// Latency : 1 cycle from input acceptance to m_axis_cq_tvalid on the selected port.
// Backpr. : One register slot per port. The input stalls only while the target slot is full.
//           Dropped frames are always accepted. Other ports keep flowing while one port stalls.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   s_axis_cq_*           - input CQ stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_cq_*           - M_COUNT output CQ streams; port i occupies slice i of each bus
//   enable                - sampled at each head beat; low drops that frame
//   status_drop           - one-cycle pulse after a dropped head beat is accepted
//   drop_count            - saturating 16-bit count of dropped frames
module pcie_us_axis_cq_demux #(
  parameter int AXIS_PCIE_DATA_WIDTH    = 128,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = 85,
  parameter int M_COUNT                 = 2,
  parameter logic [M_COUNT*7-1:0] PORT_BAR_MASK = {7'b0000010, 7'b0000001}
) (
  input  logic                                   clk,
  input  logic                                   rst_n,

  input  logic [AXIS_PCIE_DATA_WIDTH-1:0]        s_axis_cq_tdata,
  input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]        s_axis_cq_tkeep,
  input  logic                                   s_axis_cq_tvalid,
  output logic                                   s_axis_cq_tready,
  input  logic                                   s_axis_cq_tlast,
  input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0]     s_axis_cq_tuser,

  output logic [M_COUNT*AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cq_tdata,
  output logic [M_COUNT*AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cq_tkeep,
  output logic [M_COUNT-1:0]                         m_axis_cq_tvalid,
  input  logic [M_COUNT-1:0]                         m_axis_cq_tready,
  output logic [M_COUNT-1:0]                         m_axis_cq_tlast,
  output logic [M_COUNT*AXIS_PCIE_CQ_USER_WIDTH-1:0] m_axis_cq_tuser,

  input  logic                                   enable,
  output logic                                   status_drop,
  output logic [15:0]                            drop_count
);

  localparam int DW = AXIS_PCIE_DATA_WIDTH;
  localparam int KW = AXIS_PCIE_KEEP_WIDTH;
  localparam int UW = AXIS_PCIE_CQ_USER_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUTE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         port_q;      // port latched at the head of a routed frame

  logic [2:0]         bar_id;
  logic               match_vld;
  logic [1:0]         match_port;
  logic [7:0]         bar_mask8;
  logic               head_drop;

  logic [M_COUNT-1:0] slot_free;
  logic [1:0]         tgt_port;
  logic               sel_free;
  logic               accept;
  logic               head_accept;
  logic               route_beat;
  logic [M_COUNT-1:0] load;

  // Head decode. BAR ID 7 is not a real BAR. It indexes the zero pad bit of the
  // 8-bit mask, so it never matches any port.
  assign bar_id = s_axis_cq_tdata[114:112];

  always_comb begin
    match_vld  = 1'b0;
    match_port = 2'd0;
    bar_mask8  = 8'd0;
    // Walk from the highest port down so the lowest matching port wins.
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      bar_mask8 = {1'b0, PORT_BAR_MASK[i*7 +: 7]};
      if (bar_mask8[bar_id]) begin
        match_vld  = 1'b1;
        match_port = i[1:0];
      end
    end
  end

  assign head_drop = !enable || !match_vld;

  // A slot can take a new beat if it is empty or is being drained this cycle.
  assign slot_free = ~m_axis_cq_tvalid | m_axis_cq_tready;

  // At a head beat the target is still being decoded. Mid-frame it is the latched port.
  assign tgt_port = (state == IDLE) ? match_port : port_q;

  always_comb begin
    sel_free = 1'b0;
    for (int i = 0; i < M_COUNT; i++) begin
      if ({30'd0, tgt_port} == i) begin
        sel_free = slot_free[i];
      end
    end
  end

  always_comb begin
    s_axis_cq_tready = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    s_axis_cq_tready = head_drop ? 1'b1 : sel_free;
        ROUTE:   s_axis_cq_tready = sel_free;
        DROP:    s_axis_cq_tready = 1'b1;
        default: s_axis_cq_tready = 1'b0;
      endcase
    end
  end

  assign accept      = s_axis_cq_tvalid && s_axis_cq_tready;
  assign head_accept = accept && (state == IDLE);
  assign route_beat  = accept && (((state == IDLE) && !head_drop) || (state == ROUTE));

  always_comb begin
    load = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      if (route_beat && ({30'd0, tgt_port} == i)) begin
        load[i] = 1'b1;
      end
    end
  end

  // Frame tracking and drop accounting. Port selection and enable are only
  // looked at on the head beat, so mid-frame changes to enable are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      port_q      <= 2'd0;
      status_drop <= 1'b0;
      drop_count  <= 16'd0;
    end else begin
      status_drop <= head_accept && head_drop;
      if (head_accept && head_drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      case (state)
        IDLE: begin
          // A single-beat TLP (tlast on the head) leaves the FSM in IDLE.
          if (accept && !s_axis_cq_tlast) begin
            state  <= head_drop ? DROP : ROUTE;
            port_q <= match_port;
          end
        end
        ROUTE, DROP: begin
          if (accept && s_axis_cq_tlast) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-port output slots. A load wins over a drain in the same cycle, which
  // gives full throughput of one beat per cycle on each port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < M_COUNT; i++) begin
      if (!rst_n) begin
        m_axis_cq_tvalid[i]         <= 1'b0;
        m_axis_cq_tlast[i]          <= 1'b0;
        m_axis_cq_tdata[i*DW +: DW] <= '0;
        m_axis_cq_tkeep[i*KW +: KW] <= '0;
        m_axis_cq_tuser[i*UW +: UW] <= '0;
      end else if (load[i]) begin
        m_axis_cq_tvalid[i]         <= 1'b1;
        m_axis_cq_tlast[i]          <= s_axis_cq_tlast;
        m_axis_cq_tdata[i*DW +: DW] <= s_axis_cq_tdata;
        m_axis_cq_tkeep[i*KW +: KW] <= s_axis_cq_tkeep;
        m_axis_cq_tuser[i*UW +: UW] <= s_axis_cq_tuser;
      end else if (m_axis_cq_tready[i]) begin
        m_axis_cq_tvalid[i]         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_us_axis_cq_demux.sv
// Purpose : Directed bench for pcie_us_axis_cq_demux with two ports (port0 = BAR0, port1 = BAR1).
// Latency : Checks are made 1 time unit after the rising edge. Inputs change at that point too.
// Backpr. : Downstream tready is driven per test to create stalls.
module tb_pcie_us_axis_cq_demux;

  localparam int DW = 128;
  localparam int KW = 4;
  localparam int UW = 85;
  localparam int MC = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    s_tdata = '0;
  logic [KW-1:0]    s_tkeep = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic             s_tlast = 1'b0;
  logic [UW-1:0]    s_tuser = '0;
  logic [MC*DW-1:0] m_tdata;
  logic [MC*KW-1:0] m_tkeep;
  logic [MC-1:0]    m_tvalid;
  logic [MC-1:0]    m_tready = 2'b11;
  logic [MC-1:0]    m_tlast;
  logic [MC*UW-1:0] m_tuser;
  logic             en = 1'b1;
  logic             status_drop;
  logic [15:0]      drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcie_us_axis_cq_demux #(
    .AXIS_PCIE_DATA_WIDTH(DW),
    .AXIS_PCIE_KEEP_WIDTH(KW),
    .AXIS_PCIE_CQ_USER_WIDTH(UW),
    .M_COUNT(MC),
    .PORT_BAR_MASK({7'b0000010, 7'b0000001})
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_cq_tdata(s_tdata),
    .s_axis_cq_tkeep(s_tkeep),
    .s_axis_cq_tvalid(s_tvalid),
    .s_axis_cq_tready(s_tready),
    .s_axis_cq_tlast(s_tlast),
    .s_axis_cq_tuser(s_tuser),
    .m_axis_cq_tdata(m_tdata),
    .m_axis_cq_tkeep(m_tkeep),
    .m_axis_cq_tvalid(m_tvalid),
    .m_axis_cq_tready(m_tready),
    .m_axis_cq_tlast(m_tlast),
    .m_axis_cq_tuser(m_tuser),
    .enable(en),
    .status_drop(status_drop),
    .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The BAR ID sits in bits [114:112]. The tag is placed in two other fields
  // so that every beat is unique.
  function automatic logic [127:0] mk(input logic [2:0] bar, input logic [15:0] t);
    logic [127:0] d;
    d            = '0;
    d[114:112]   = bar;
    d[15:0]      = t;
    d[127:120]   = t[7:0];
    return d;
  endfunction

  function automatic logic [84:0] usr(input logic [15:0] t);
    return {5'h0, 16'hA5A5, 48'h0, t};
  endfunction

  task automatic drive(input logic [2:0] bar, input logic [15:0] t, input logic last);
    s_tdata  = mk(bar, t);
    s_tuser  = usr(t);
    s_tlast  = last;
    s_tkeep  = 4'hF;
    s_tvalid = 1'b1;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: input offered during reset must not be accepted.
    drive(3'd0, 16'h0001, 1'b1);
    check("rst_tready", s_tready, 0);
    tick; tick;
    check("rst_vld", m_tvalid, 0);
    check("rst_drop_cnt", drop_count, 0);
    check("rst_status", status_drop, 0);
    check("rst_data0", m_tdata[DW-1:0], 0);
    s_tvalid = 1'b0;
    rst_n    = 1'b1;

    // 1: BAR0 single-beat read goes to port0 one cycle later.
    drive(3'd0, 16'h0011, 1'b1);
    check("t1_rdy", s_tready, 1);
    tick;
    s_tvalid = 1'b0;
    check("t1_vld", m_tvalid, 2'b01);
    check("t1_data0", m_tdata[DW-1:0], mk(3'd0, 16'h0011));
    check("t1_user0", m_tuser[UW-1:0], usr(16'h0011));
    check("t1_last0", m_tlast[0], 1);
    check("t1_keep0", m_tkeep[KW-1:0], 4'hF);
    check("t1_drop_cnt", drop_count, 0);
    tick;
    check("t1_drain", m_tvalid, 0);

    // 2: BAR1 3-beat write with port1 stalled for 5 cycles after beat 1 lands.
    m_tready = 2'b01;
    drive(3'd1, 16'h0021, 1'b0);
    check("t2_head_rdy", s_tready, 1);
    tick;
    check("t2_b1_vld", m_tvalid, 2'b10);
    check("t2_b1_data", m_tdata[2*DW-1:DW], mk(3'd1, 16'h0021));
    check("t2_b1_last", m_tlast[1], 0);
    drive(3'd1, 16'h0022, 1'b0);
    check("t2_stall_rdy", s_tready, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t2_stall_rdy_k", s_tready, 0);
    end
    check("t2_stall_hold", m_tdata[2*DW-1:DW], mk(3'd1, 16'h0021));
    m_tready = 2'b11;
    #1;
    check("t2_rel_rdy", s_tready, 1);
    tick;
    check("t2_b2_vld", m_tvalid, 2'b10);
    check("t2_b2_data", m_tdata[2*DW-1:DW], mk(3'd1, 16'h0022));
    check("t2_b2_last", m_tlast[1], 0);
    drive(3'd1, 16'h0023, 1'b1);
    tick;
    s_tvalid = 1'b0;
    check("t2_b3_data", m_tdata[2*DW-1:DW], mk(3'd1, 16'h0023));
    check("t2_b3_last", m_tlast[1], 1);
    tick;
    check("t2_drain", m_tvalid, 0);

    // 3: BAR2 2-beat frame is dropped and counted once.
    drive(3'd2, 16'h0031, 1'b0);
    check("t3_h_rdy", s_tready, 1);
    tick;
    check("t3_h_vld", m_tvalid, 0);
    check("t3_status", status_drop, 1);
    check("t3_cnt", drop_count, 1);
    drive(3'd0, 16'h0032, 1'b1);
    check("t3_b2_rdy", s_tready, 1);
    tick;
    s_tvalid = 1'b0;
    check("t3_b2_vld", m_tvalid, 0);
    check("t3_status_off", status_drop, 0);
    check("t3_cnt_hold", drop_count, 1);

    // 4: port0 stalled holding a beat; a BAR1 frame still gets through to port1.
    m_tready = 2'b10;
    drive(3'd0, 16'h0041, 1'b1);
    tick;
    check("t4_p0_vld", m_tvalid, 2'b01);
    drive(3'd1, 16'h0042, 1'b1);
    check("t4_p1_rdy", s_tready, 1);
    tick;
    check("t4_both_vld", m_tvalid, 2'b11);
    check("t4_p1_data", m_tdata[2*DW-1:DW], mk(3'd1, 16'h0042));
    check("t4_p0_hold", m_tdata[DW-1:0], mk(3'd0, 16'h0041));
    drive(3'd0, 16'h0043, 1'b1);
    check("t4_p0_full_rdy", s_tready, 0);
    m_tready = 2'b11;
    #1;
    check("t4_p0_rel_rdy", s_tready, 1);
    tick;
    s_tvalid = 1'b0;
    check("t4_p0_vld2", m_tvalid, 2'b01);
    check("t4_p0_data2", m_tdata[DW-1:0], mk(3'd0, 16'h0043));
    tick;

    // 5: enable low at the head drops the whole frame, even though it rises before beat 2.
    en = 1'b0;
    drive(3'd0, 16'h0051, 1'b0);
    check("t5_h_rdy", s_tready, 1);
    tick;
    en = 1'b1;
    check("t5_status", status_drop, 1);
    check("t5_cnt", drop_count, 2);
    check("t5_h_vld", m_tvalid, 0);
    drive(3'd0, 16'h0052, 1'b1);
    check("t5_b2_rdy", s_tready, 1);
    tick;
    check("t5_b2_vld", m_tvalid, 0);
    drive(3'd0, 16'h0053, 1'b1);
    tick;
    s_tvalid = 1'b0;
    check("t5_next_vld", m_tvalid, 2'b01);
    check("t5_next_data", m_tdata[DW-1:0], mk(3'd0, 16'h0053));
    check("t5_cnt_hold", drop_count, 2);
    tick;

    // 6: reset between beat 1 and beat 2 of a BAR1 frame. The former beat 2 is decoded as a head.
    drive(3'd1, 16'h0061, 1'b0);
    tick;
    check("t6_b1_vld", m_tvalid, 2'b10);
    drive(3'd0, 16'h0062, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rdy", s_tready, 0);
    tick;
    check("t6_rst_vld", m_tvalid, 0);
    check("t6_rst_cnt", drop_count, 0);
    rst_n = 1'b1;
    #1;
    check("t6_head_rdy", s_tready, 1);
    tick;
    s_tvalid = 1'b0;
    check("t6_head_vld", m_tvalid, 2'b01);
    check("t6_head_data", m_tdata[DW-1:0], mk(3'd0, 16'h0062));
    check("t6_head_last", m_tlast[0], 1);
    tick;

    // BAR ID 7 never matches a port.
    drive(3'd7, 16'h0071, 1'b1);
    check("bar7_rdy", s_tready, 1);
    tick;
    s_tvalid = 1'b0;
    check("bar7_vld", m_tvalid, 0);
    check("bar7_status", status_drop, 1);
    check("bar7_cnt", drop_count, 1);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
